pong_match_ctrl: RTL and testbench

Match-level sequencer for the Pong game. Sits between the debounced player buttons / ball-physics logic and the score display. Owns the game state machine, both scores and the serve countdown. Tells the ball datapath when to recentre (serve), which way to launch, and when it may move.

---
 rtl/pong_match_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: game state machine, scores, serve countdown and ball launch control.
// All outputs are registered; button and point inputs are rising-edge qualified internally.
module pong_match_ctrl #(
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned SERVE_DELAY = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       p1_point,
    input  logic       p2_point,
    output logic       ball_enable,
    output logic       ball_serve,
    output logic       serve_dir,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StServe    = 3'd1;
    localparam logic [2:0] StPlay     = 3'd2;
    localparam logic [2:0] StPause    = 3'd3;
    localparam logic [2:0] StGameOver = 3'd4;

    localparam logic [3:0] WinScore   = 4'(WIN_SCORE);
    localparam logic [7:0] ServeDelay = 8'(SERVE_DELAY);
    localparam logic [3:0] ScoreMax   = 4'd15;

    localparam logic [1:0] WinNone = 2'b00;
    localparam logic [1:0] WinP1   = 2'b01;
    localparam logic [1:0] WinP2   = 2'b10;

    logic       start_prev_q, pause_prev_q, p1_prev_q, p2_prev_q;
    logic       start_edge, pause_edge, p1_edge, p2_edge;

    logic [2:0] state_q, state_d;
    logic [7:0] counter_q, counter_d;
    logic [3:0] p1_score_q, p1_score_d;
    logic [3:0] p2_score_q, p2_score_d;
    logic [1:0] winner_q, winner_d;
    logic       serve_dir_q, serve_dir_d;
    logic       ball_serve_q, ball_serve_d;
    logic       ball_enable_q, ball_enable_d;

    logic [3:0] p1_inc, p2_inc;
    logic       serve_launch;

    assign start_edge = start_btn & ~start_prev_q;
    assign pause_edge = pause_btn & ~pause_prev_q;
    assign p1_edge    = p1_point & ~p1_prev_q;
    assign p2_edge    = p2_point & ~p2_prev_q;

    // Saturating increments; the win compare uses these post-increment values.
    assign p1_inc = (p1_score_q == ScoreMax) ? ScoreMax : p1_score_q + 4'd1;
    assign p2_inc = (p2_score_q == ScoreMax) ? ScoreMax : p2_score_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        p1_score_d   = p1_score_q;
        p2_score_d   = p2_score_q;
        winner_d     = winner_q;
        serve_dir_d  = serve_dir_q;
        ball_serve_d = 1'b0;
        serve_launch = 1'b0;

        case (state_q)
            StIdle: begin
                p1_score_d = 4'd0;
                p2_score_d = 4'd0;
                winner_d   = WinNone;
                if (start_edge) begin
                    serve_launch = 1'b1;
                    serve_dir_d  = 1'b1;
                end
            end

            StServe: begin
                if (frame_tick) begin
                    counter_d = (counter_q == 8'd0) ? 8'd0 : counter_q - 8'd1;
                    if (counter_q <= 8'd1) begin
                        state_d = StPlay;
                    end
                end
            end

            StPlay: begin
                if (p1_edge && p2_edge) begin
                    // Simultaneous points count as a let: replay toward the same side.
                    serve_launch = 1'b1;
                end else if (p1_edge) begin
                    p1_score_d = p1_inc;
                    if (p1_inc == WinScore) begin
                        state_d  = StGameOver;
                        winner_d = WinP1;
                    end else begin
                        serve_launch = 1'b1;
                        serve_dir_d  = 1'b0;
                    end
                end else if (p2_edge) begin
                    p2_score_d = p2_inc;
                    if (p2_inc == WinScore) begin
                        state_d  = StGameOver;
                        winner_d = WinP2;
                    end else begin
                        serve_launch = 1'b1;
                        serve_dir_d  = 1'b1;
                    end
                end else if (pause_edge) begin
                    state_d = StPause;
                end
            end

            StPause: begin
                if (pause_edge) begin
                    state_d = StPlay;
                end
            end

            StGameOver: begin
                if (start_edge) begin
                    p1_score_d   = 4'd0;
                    p2_score_d   = 4'd0;
                    winner_d     = WinNone;
                    serve_dir_d  = 1'b1;
                    serve_launch = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (serve_launch) begin
            state_d      = StServe;
            ball_serve_d = 1'b1;
            counter_d    = ServeDelay;
        end

        ball_enable_d = (state_d == StPlay);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_prev_q  <= 1'b1;
            pause_prev_q  <= 1'b1;
            p1_prev_q     <= 1'b0;
            p2_prev_q     <= 1'b0;
            state_q       <= StIdle;
            counter_q     <= 8'd0;
            p1_score_q    <= 4'd0;
            p2_score_q    <= 4'd0;
            winner_q      <= WinNone;
            serve_dir_q   <= 1'b1;
            ball_serve_q  <= 1'b0;
            ball_enable_q <= 1'b0;
        end else begin
            start_prev_q  <= start_btn;
            pause_prev_q  <= pause_btn;
            p1_prev_q     <= p1_point;
            p2_prev_q     <= p2_point;
            state_q       <= state_d;
            counter_q     <= counter_d;
            p1_score_q    <= p1_score_d;
            p2_score_q    <= p2_score_d;
            winner_q      <= winner_d;
            serve_dir_q   <= serve_dir_d;
            ball_serve_q  <= ball_serve_d;
            ball_enable_q <= ball_enable_d;
        end
    end

    assign ball_enable = ball_enable_q;
    assign ball_serve  = ball_serve_q;
    assign serve_dir   = serve_dir_q;
    assign p1_score    = p1_score_q;
    assign p2_score    = p2_score_q;
    assign winner      = winner_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed match scenarios plus random play, all checked every
// cycle against a behavioural match model.
module tb_pong_match_ctrl;

    localparam int WIN = 5;
    localparam int SD  = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic frame_tick = 1'b0;
    logic start_btn = 1'b0;
    logic pause_btn = 1'b0;
    logic p1_point = 1'b0;
    logic p2_point = 1'b0;
    logic       ball_enable, ball_serve, serve_dir;
    logic [3:0] p1_score, p2_score;
    logic [1:0] winner;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail = 0;
    int pulses;

    always #5 clk = ~clk;

    pong_match_ctrl #(
        .WIN_SCORE  (WIN),
        .SERVE_DELAY(SD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .start_btn  (start_btn),
        .pause_btn  (pause_btn),
        .p1_point   (p1_point),
        .p2_point   (p2_point),
        .ball_enable(ball_enable),
        .ball_serve (ball_serve),
        .serve_dir  (serve_dir),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .winner     (winner),
        .state      (state)
    );

    // Match model: st uses the visible state numbering, ticks counts frame ticks seen in serve.
    typedef struct packed {
        int st;
        int p1;
        int p2;
        int w;
        int ticks;
        bit dir;
        bit srv;
        bit en;
    } mstate_t;

    mstate_t m;
    bit mp_start, mp_pause, mp_p1, mp_p2;

    function automatic mstate_t model_next(mstate_t c, bit se, bit pe, bit ae, bit be, bit tick);
        mstate_t n;
        bit launch;
        n = c;
        launch = 1'b0;
        n.srv = 1'b0;
        case (c.st)
            0: begin
                n.p1 = 0;
                n.p2 = 0;
                n.w = 0;
                if (se) begin
                    launch = 1'b1;
                    n.dir = 1'b1;
                end
            end
            1: begin
                if (tick) begin
                    n.ticks = c.ticks + 1;
                    if (n.ticks >= SD) n.st = 2;
                end
            end
            2: begin
                if (ae && be) begin
                    launch = 1'b1;
                end else if (ae) begin
                    n.p1 = (c.p1 < 15) ? c.p1 + 1 : 15;
                    if (n.p1 == WIN) begin
                        n.st = 4;
                        n.w = 1;
                    end else begin
                        launch = 1'b1;
                        n.dir = 1'b0;
                    end
                end else if (be) begin
                    n.p2 = (c.p2 < 15) ? c.p2 + 1 : 15;
                    if (n.p2 == WIN) begin
                        n.st = 4;
                        n.w = 2;
                    end else begin
                        launch = 1'b1;
                        n.dir = 1'b1;
                    end
                end else if (pe) begin
                    n.st = 3;
                end
            end
            3: begin
                if (pe) n.st = 2;
            end
            4: begin
                if (se) begin
                    n.p1 = 0;
                    n.p2 = 0;
                    n.w = 0;
                    n.dir = 1'b1;
                    launch = 1'b1;
                end
            end
            default: n.st = 0;
        endcase
        if (launch) begin
            n.st = 1;
            n.srv = 1'b1;
            n.ticks = 0;
        end
        n.en = (n.st == 2);
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m <= '{st: 0, p1: 0, p2: 0, w: 0, ticks: 0, dir: 1'b1, srv: 1'b0, en: 1'b0};
            mp_start <= 1'b1;
            mp_pause <= 1'b1;
            mp_p1 <= 1'b0;
            mp_p2 <= 1'b0;
        end else begin
            m <= model_next(m, start_btn & ~mp_start, pause_btn & ~mp_pause,
                            p1_point & ~mp_p1, p2_point & ~mp_p2, frame_tick);
            mp_start <= start_btn;
            mp_pause <= pause_btn;
            mp_p1 <= p1_point;
            mp_p2 <= p2_point;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: outputs against the model.
    always @(negedge clk) begin
        check("m_state", int'(state), m.st);
        check("m_p1_score", int'(p1_score), m.p1);
        check("m_p2_score", int'(p2_score), m.p2);
        check("m_winner", int'(winner), m.w);
        check("m_serve_dir", int'(serve_dir), int'(m.dir));
        check("m_ball_serve", int'(ball_serve), int'(m.srv));
        check("m_ball_enable", int'(ball_enable), int'(m.en));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(1);
    endtask

    task automatic serve_wait();
        repeat (SD) tick();
        check("serve_to_play", int'(state), 2);
    endtask

    task automatic score(input bit who);
        if (who) p2_point = 1'b1;
        else p1_point = 1'b1;
        step(1);
        p1_point = 1'b0;
        p2_point = 1'b0;
        step(1);
        if (m.st == 1) serve_wait();
    endtask

    initial begin
        // Start held through reset release must not fire.
        #1 reset_n = 1'b0;
        start_btn = 1'b1;
        step(3);
        reset_n = 1'b1;
        step(3);
        check("held_start_idle", int'(state), 0);
        check("reset_dir", int'(serve_dir), 1);
        check("reset_enable", int'(ball_enable), 0);
        start_btn = 1'b0;
        step(1);
        check("still_idle", int'(state), 0);
        start_btn = 1'b1;
        step(1);
        check("start_serve", int'(state), 1);
        check("start_pulse", int'(ball_serve), 1);
        check("start_dir", int'(serve_dir), 1);
        start_btn = 1'b0;
        step(1);
        check("pulse_one_clk", int'(ball_serve), 0);
        tick();
        tick();
        check("serve_after_2", int'(state), 1);
        check("serve_no_enable", int'(ball_enable), 0);
        tick();
        check("play_after_3", int'(state), 2);
        check("enable_in_play", int'(ball_enable), 1);

        // p2_point held for 10 clocks scores once.
        pulses = 0;
        p2_point = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            pulses += int'(ball_serve);
        end
        p2_point = 1'b0;
        check("p2_once", int'(p2_score), 1);
        check("p2_state", int'(state), 1);
        check("p2_dir", int'(serve_dir), 1);
        check("p2_pulses", pulses, 1);
        serve_wait();

        score(1'b0);
        check("p1_dir_left", int'(serve_dir), 0);
        check("p1_score_1", int'(p1_score), 1);

        // Let: both points in one cycle.
        p1_point = 1'b1;
        p2_point = 1'b1;
        step(1);
        p1_point = 1'b0;
        p2_point = 1'b0;
        check("let_p1", int'(p1_score), 1);
        check("let_p2", int'(p2_score), 1);
        check("let_state", int'(state), 1);
        check("let_dir", int'(serve_dir), 0);
        check("let_pulse", int'(ball_serve), 1);
        step(1);
        serve_wait();

        // Pause, ignored point, resume.
        pause_btn = 1'b1;
        step(1);
        check("pause_state", int'(state), 3);
        check("pause_enable", int'(ball_enable), 0);
        pause_btn = 1'b0;
        p1_point = 1'b1;
        step(1);
        p1_point = 1'b0;
        step(1);
        check("pause_point_ignored", int'(p1_score), 1);
        check("pause_hold", int'(state), 3);
        pause_btn = 1'b1;
        step(1);
        check("resume_state", int'(state), 2);
        check("resume_no_serve", int'(ball_serve), 0);
        check("resume_enable", int'(ball_enable), 1);
        pause_btn = 1'b0;
        step(1);

        // Reach 3-2, then asynchronous reset mid-play.
        score(1'b0);
        score(1'b0);
        score(1'b1);
        check("score_3", int'(p1_score), 3);
        check("score_2", int'(p2_score), 2);
        reset_n = 1'b0;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_p1", int'(p1_score), 0);
        check("arst_p2", int'(p2_score), 0);
        check("arst_enable", int'(ball_enable), 0);
        check("arst_serve", int'(ball_serve), 0);
        check("arst_dir", int'(serve_dir), 1);
        check("arst_winner", int'(winner), 0);
        step(1);
        reset_n = 1'b1;
        step(1);
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        step(1);
        serve_wait();

        // Play to a P1 win, then restart.
        repeat (WIN) score(1'b0);
        check("win_p1_score", int'(p1_score), WIN);
        check("win_winner", int'(winner), 1);
        check("win_state", int'(state), 4);
        check("win_enable", int'(ball_enable), 0);
        score(1'b1);
        score(1'b0);
        check("frozen_p1", int'(p1_score), WIN);
        check("frozen_p2", int'(p2_score), 0);
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        check("restart_p1", int'(p1_score), 0);
        check("restart_winner", int'(winner), 0);
        check("restart_state", int'(state), 1);
        check("restart_pulse", int'(ball_serve), 1);
        step(1);

        // Random play; ticks are withheld in the cycle the serve pulse is visible.
        for (int c = 0; c < 6000; c++) begin
            frame_tick = ($urandom_range(1) == 1) && !m.srv;
            if ($urandom_range(15) == 0) start_btn = ~start_btn;
            if ($urandom_range(11) == 0) pause_btn = ~pause_btn;
            if ($urandom_range(49) == 0 && !p1_point && !p2_point) begin
                p1_point = 1'b1;
                p2_point = 1'b1;
            end else begin
                if ($urandom_range(4) == 0) p1_point = ~p1_point;
                if ($urandom_range(4) == 0) p2_point = ~p2_point;
            end
            if (c == 3000) reset_n = 1'b0;
            if (c == 3002) reset_n = 1'b1;
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
